// File: rtl/fetch_responder_pkg.sv
// fetch_responder_pkg: shared constants, rw encoding and response entry layout
// for the fetch responder.
package fetch_responder_pkg;

    localparam logic [31:0] FETCH_BASE_ADDR = 32'h80020000;
    localparam logic        RW_WRITE        = 1'b0;
    localparam logic        RW_READ         = 1'b1;

    typedef struct packed {
        logic [31:0] data;
        logic [31:0] addr;
        logic        err;
    } rsp_entry_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v, input logic en);
        return (en && v != 32'hFFFF_FFFF) ? v + 32'd1 : v;
    endfunction

endpackage

// File: rtl/fetch_responder_rsp_fifo_2.sv
// rsp_fifo_2: two-entry in-order response queue; the head entry is a register
// so the response outputs stay stable while the consumer stalls.
module rsp_fifo_2
    import fetch_responder_pkg::*;
(
    input  logic       clock,
    input  logic       reset,
    input  logic       push,
    input  rsp_entry_t push_entry,
    input  logic       pop,
    output logic [1:0] count,
    output rsp_entry_t head
);

    rsp_entry_t head_q, head_d, tail_q, tail_d;
    logic [1:0] count_q, count_d, after_pop;

    // Pop is applied first so a full queue can pop and push in one cycle.
    always_comb begin
        after_pop = count_q - {1'b0, pop};
        head_d    = (push && after_pop == 2'd0) ? push_entry : (pop ? tail_q : head_q);
        tail_d    = (push && after_pop != 2'd0) ? push_entry : tail_q;
        count_d   = after_pop + {1'b0, push};
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= 2'd0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    assign count = count_q;
    assign head  = head_q;

endmodule

// File: rtl/fetch_responder.sv
// fetch_responder: instruction-store responder translating CPU addresses to word
// offsets; FETCH_RESPONDER_STATS_EN adds saturating read/write/error counters.
module fetch_responder
    import fetch_responder_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = FETCH_BASE_ADDR,
    parameter int          DEPTH_WORDS = 1024
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        w_req_valid,
    output logic        w_req_ready,
    input  logic        w_req_rw,
    input  logic [31:0] w_req_addr_32,
    input  logic [31:0] w_req_data_32,
    output logic        w_rsp_valid,
    input  logic        w_rsp_ready,
    output logic [31:0] w_rsp_data_32,
    output logic [31:0] w_rsp_addr_32,
    output logic        w_rsp_err,
    output logic        w_wr_err
`ifdef FETCH_RESPONDER_STATS_EN
    ,
    output logic [31:0] w_rd_count_32,
    output logic [31:0] w_wr_count_32,
    output logic [31:0] w_err_count_32
`endif
);

    localparam int          IW    = $clog2(DEPTH_WORDS);
    localparam logic [31:0] LIMIT = 32'(DEPTH_WORDS * 4);

    logic [31:0] mem_q [DEPTH_WORDS];
    logic [31:0] offset;
    logic [IW-1:0] index;
    logic        addr_err, pop, accept, push, wr_en, wr_fault;
    logic        wr_err_d, wr_err_q;
    logic [1:0]  count;
    rsp_entry_t  head, push_entry;

    // Addresses below the base wrap to a huge offset and fail the range check.
    always_comb begin
        offset      = w_req_addr_32 - BASE_ADDR;
        index       = offset[IW+1:2];
        addr_err    = (offset[1:0] != 2'b00) || (offset >= LIMIT);
        pop         = w_rsp_valid & w_rsp_ready;
        w_req_ready = reset & ((count != 2'd2) | pop);
        accept      = w_req_valid & w_req_ready;
        push        = accept & (w_req_rw == RW_READ);
        wr_en       = accept & (w_req_rw == RW_WRITE) & ~addr_err;
        wr_fault    = accept & (w_req_rw == RW_WRITE) & addr_err;
        push_entry  = '{data: addr_err ? 32'd0 : mem_q[index], addr: w_req_addr_32, err: addr_err};
        wr_err_d    = wr_err_q | wr_fault;
    end

    always_ff @(posedge clock) begin
        if (wr_en) mem_q[index] <= w_req_data_32;
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) wr_err_q <= 1'b0;
        else        wr_err_q <= wr_err_d;
    end

    rsp_fifo_2 u_rsp_fifo (
        .clock      (clock),
        .reset      (reset),
        .push       (push),
        .push_entry (push_entry),
        .pop        (pop),
        .count      (count),
        .head       (head)
    );

    assign w_rsp_valid   = count != 2'd0;
    assign w_rsp_data_32 = head.data;
    assign w_rsp_addr_32 = head.addr;
    assign w_rsp_err     = head.err;
    assign w_wr_err      = wr_err_q;

`ifdef FETCH_RESPONDER_STATS_EN
    logic [31:0] rd_cnt_q, rd_cnt_d, wr_cnt_q, wr_cnt_d, err_cnt_q, err_cnt_d;

    always_comb begin
        rd_cnt_d  = sat_inc(rd_cnt_q, push);
        wr_cnt_d  = sat_inc(wr_cnt_q, accept & (w_req_rw == RW_WRITE));
        err_cnt_d = sat_inc(err_cnt_q, accept & addr_err);
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            rd_cnt_q  <= '0;
            wr_cnt_q  <= '0;
            err_cnt_q <= '0;
        end else begin
            rd_cnt_q  <= rd_cnt_d;
            wr_cnt_q  <= wr_cnt_d;
            err_cnt_q <= err_cnt_d;
        end
    end

    assign w_rd_count_32  = rd_cnt_q;
    assign w_wr_count_32  = wr_cnt_q;
    assign w_err_count_32 = err_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_responder.sv
// tb_fetch_responder: scoreboard bench for fetch_responder; read expectations are
// queued at acceptance and compared when the response is popped.
module tb_fetch_responder;

    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h80020000;

    typedef struct packed {
        logic [31:0] d;
        logic [31:0] a;
        logic        e;
    } exp_t;

    logic        clock = 1'b0, reset = 1'b0;
    logic        w_req_valid = 1'b0, w_req_rw = 1'b0, w_rsp_ready = 1'b1;
    logic [31:0] w_req_addr_32 = '0, w_req_data_32 = '0;
    logic        w_req_ready, w_rsp_valid, w_rsp_err, w_wr_err;
    logic [31:0] w_rsp_data_32, w_rsp_addr_32;
`ifdef FETCH_RESPONDER_STATS_EN
    logic [31:0] w_rd_count_32, w_wr_count_32, w_err_count_32;
`endif

    int   n_pass = 0, n_chk = 0, cyc = 0;
    exp_t sb[$];
    logic [31:0] model [int];

    fetch_responder #(.BASE_ADDR(BASE), .DEPTH_WORDS(DEPTH)) dut (
        .clock         (clock),
        .reset         (reset),
        .w_req_valid   (w_req_valid),
        .w_req_ready   (w_req_ready),
        .w_req_rw      (w_req_rw),
        .w_req_addr_32 (w_req_addr_32),
        .w_req_data_32 (w_req_data_32),
        .w_rsp_valid   (w_rsp_valid),
        .w_rsp_ready   (w_rsp_ready),
        .w_rsp_data_32 (w_rsp_data_32),
        .w_rsp_addr_32 (w_rsp_addr_32),
        .w_rsp_err     (w_rsp_err),
        .w_wr_err      (w_wr_err)
`ifdef FETCH_RESPONDER_STATS_EN
        ,
        .w_rd_count_32 (w_rd_count_32),
        .w_wr_count_32 (w_wr_count_32),
        .w_err_count_32(w_err_count_32)
`endif
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", tag, got, exp);
    endtask

    // Pops happen at the next posedge; sample late in the low phase.
    always @(negedge clock) begin
        exp_t e;
        #4;
        if (reset && w_rsp_valid && w_rsp_ready) begin
            if (sb.size() == 0) check("rsp_unexpected", 32'(sb.size()), 32'd1);
            else begin
                e = sb.pop_front();
                check("rsp_data", w_rsp_data_32, e.d);
                check("rsp_addr", w_rsp_addr_32, e.a);
                check("rsp_err", 32'(w_rsp_err), 32'(e.e));
            end
        end
    end

    task automatic req(input logic rw, input logic [31:0] a, input logic [31:0] d, output int acc);
        logic [31:0] off;
        logic        err;
        exp_t        e;
        int          n;
        off = a - BASE;
        err = (off[1:0] != 2'b00) || (off >= 32'(DEPTH * 4));
        acc = -1;
        n   = 0;
        @(negedge clock);
        w_req_valid = 1'b1; w_req_rw = rw; w_req_addr_32 = a; w_req_data_32 = d;
        #4;
        while (!w_req_ready && n < 50) begin
            @(negedge clock);
            #4;
            n++;
        end
        if (!w_req_ready) check("req_timeout", 32'(w_req_ready), 32'd1);
        else begin
            if (rw) begin
                e.d = err ? 32'd0 : model[int'(off[31:2])];
                e.a = a;
                e.e = err;
                sb.push_back(e);
            end else if (!err) model[int'(off[31:2])] = d;
            @(posedge clock);
            #1;
            acc = cyc;
            if (rw) check("rd_latency", 32'(w_rsp_valid), 32'd1);
        end
        w_req_valid = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        int acc, acc3, raise;
        #12;
        check("rst_rsp_valid", 32'(w_rsp_valid), 32'd0);
        check("rst_rsp_data", w_rsp_data_32, 32'd0);
        check("rst_rsp_addr", w_rsp_addr_32, 32'd0);
        check("rst_rsp_err", 32'(w_rsp_err), 32'd0);
        check("rst_wr_err", 32'(w_wr_err), 32'd0);
        check("rst_req_ready", 32'(w_req_ready), 32'd0);
        @(negedge clock);
        reset = 1'b1;
        #1 check("ready_after_reset", 32'(w_req_ready), 32'd1);

        req(1'b0, BASE, 32'h20080005, acc);
        req(1'b0, BASE + 32'd4, 32'h01095020, acc);
        req(1'b1, BASE, 32'd0, acc);
        check("load_rd0", w_rsp_data_32, 32'h20080005);
        req(1'b1, BASE + 32'd4, 32'd0, acc);
        check("load_rd1", w_rsp_data_32, 32'h01095020);
        check("load_rd1_err", 32'(w_rsp_err), 32'd0);

        repeat (2) @(negedge clock);
        w_rsp_ready = 1'b0;
        req(1'b1, BASE, 32'd0, acc);
        req(1'b1, BASE + 32'd4, 32'd0, acc);
        raise = 0;
        fork
            req(1'b1, BASE, 32'd0, acc3);
            begin
                @(negedge clock);
                #4 check("full_ready", 32'(w_req_ready), 32'd0);
                @(negedge clock);
                w_rsp_ready = 1'b1;
                raise = cyc;
            end
        join
        check("third_on_pop", 32'(acc3), 32'(raise + 1));

        repeat (4) @(negedge clock);
        req(1'b1, BASE + 32'd2, 32'd0, acc);
        check("misalign_err", 32'(w_rsp_err), 32'd1);
        check("misalign_data", w_rsp_data_32, 32'd0);
        req(1'b1, 32'h8001FFFC, 32'd0, acc);
        check("below_base_err", 32'(w_rsp_err), 32'd1);
        check("wr_err_clear", 32'(w_wr_err), 32'd0);
        req(1'b0, BASE + 32'(DEPTH * 4), 32'h12345678, acc);
        check("wr_err_sticky", 32'(w_wr_err), 32'd1);
        req(1'b1, BASE, 32'd0, acc);
        check("store_unchanged", w_rsp_data_32, 32'h20080005);

        req(1'b0, BASE + 32'h10, 32'hDEADBEEF, acc);
        req(1'b1, BASE + 32'h10, 32'd0, acc);
        check("wr_then_rd", w_rsp_data_32, 32'hDEADBEEF);

        repeat (2) @(negedge clock);
        w_rsp_ready = 1'b0;
        req(1'b1, BASE + 32'h10, 32'd0, acc);
        req(1'b1, BASE, 32'd0, acc);
        @(negedge clock);
        #2 reset = 1'b0;
        #1;
        check("midrst_rsp_valid", 32'(w_rsp_valid), 32'd0);
        check("midrst_wr_err", 32'(w_wr_err), 32'd0);
        check("midrst_req_ready", 32'(w_req_ready), 32'd0);
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        w_rsp_ready = 1'b1;
        req(1'b1, BASE + 32'h10, 32'd0, acc);
        check("store_survives", w_rsp_data_32, 32'hDEADBEEF);

`ifdef FETCH_RESPONDER_STATS_EN
        repeat (3) @(negedge clock);
        #2 reset = 1'b0;
        #1 check("stats_rst_rd", w_rd_count_32, 32'd0);
        sb.delete();
        @(negedge clock);
        reset = 1'b1;
        req(1'b1, BASE, 32'd0, acc);
        req(1'b1, BASE + 32'd4, 32'd0, acc);
        req(1'b0, BASE + 32'h20, 32'h11111111, acc);
        req(1'b1, BASE + 32'h10, 32'd0, acc);
        req(1'b1, BASE + 32'h20, 32'd0, acc);
        req(1'b0, BASE + 32'h24, 32'h22222222, acc);
        req(1'b1, BASE + 32'h24, 32'd0, acc);
        req(1'b1, BASE + 32'd1, 32'd0, acc);
        check("stats_rd", w_rd_count_32, 32'd6);
        check("stats_wr", w_wr_count_32, 32'd2);
        check("stats_err", w_err_count_32, 32'd1);
`endif

        repeat (5) @(negedge clock);
        check("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
